// File: rtl/regfile_2r1w_pkg.sv
// Shared types and helpers for the 2-read/1-write register file.
// The byte-lane merge is used by the write path and by the write-to-read bypass.
package rf_pkg;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_SWEEP = 1'b1
  } rf_state_e;

  localparam int RF_LANE_W = 8;

  // One byte lane of a partial write: the enabled lane takes the new byte.
  function automatic logic [RF_LANE_W-1:0] be_merge(
    input logic [RF_LANE_W-1:0] old_val,
    input logic [RF_LANE_W-1:0] new_val,
    input logic                 be
  );
    return be ? new_val : old_val;
  endfunction

endpackage

// File: rtl/regfile_2r1w_if.sv
// Bus bundle for regfile_2r1w: write port, two read ports, clear control and status.
interface regfile_2r1w_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int BE_W   = DATA_W / 8;

  logic              WrEn;
  logic [ADDR_W-1:0] WrAddr;
  logic [DATA_W-1:0] WrData;
  logic [BE_W-1:0]   WrBe;

  logic              RdEnA;
  logic [ADDR_W-1:0] RdAddrA;
  logic [DATA_W-1:0] RdDataA;
  logic              RdValidA;

  logic              RdEnB;
  logic [ADDR_W-1:0] RdAddrB;
  logic [DATA_W-1:0] RdDataB;
  logic              RdValidB;

  logic              Clr;
  logic              ClrBusy;
  logic              AddrErr;

  modport master (
    output WrEn, WrAddr, WrData, WrBe,
    output RdEnA, RdAddrA, RdEnB, RdAddrB,
    output Clr,
    input  RdDataA, RdValidA, RdDataB, RdValidB,
    input  ClrBusy, AddrErr
  );

  modport slave (
    input  WrEn, WrAddr, WrData, WrBe,
    input  RdEnA, RdAddrA, RdEnB, RdAddrB,
    input  Clr,
    output RdDataA, RdValidA, RdDataB, RdValidB,
    output ClrBusy, AddrErr
  );

endinterface

// File: rtl/regfile_2r1w_rd_port.sv
// One registered read port: range check, same-cycle bypass of the entry being
// written this cycle, and the output data/valid registers.
module rf_read_port #(
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] mem [DEPTH],
  input  logic              byp_en,
  input  logic [ADDR_W-1:0] byp_addr,
  input  logic [DATA_W-1:0] byp_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              addr_err
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic              in_range;
  logic              byp_hit;
  logic [DATA_W-1:0] rd_next;

  assign in_range = {1'b0, rd_addr} < DEPTH_L;
  assign byp_hit  = byp_en && (byp_addr == rd_addr);
  assign addr_err = rd_en && !in_range;

  // Out-of-range reads return zero; a hit on this cycle's write returns the post-write entry.
  always_comb begin
    rd_next = '0;
    if (in_range) begin
      rd_next = byp_hit ? byp_data : mem[rd_addr];
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_next;
      end
    end
  end

endmodule

// File: rtl/regfile_2r1w.sv
// Parametrised register file with one byte-enabled write port, two registered
// read ports, write-to-read bypass, address checking and a background clear sweep.
module regfile_2r1w
  import rf_pkg::*;
#(
  parameter int                DATA_W  = 16,
  parameter int                DEPTH   = 8,
  parameter logic [DATA_W-1:0] RST_VAL = {DATA_W{1'b0}}
) (
  input logic           CLK,
  input logic           RST,
  regfile_2r1w_if.slave bus
);

  localparam int              ADDR_W   = $clog2(DEPTH);
  localparam int              BE_W     = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              clr_we;

  logic              wr_in_range;
  logic              wr_commit;
  logic [DATA_W-1:0] wr_old;
  logic [DATA_W-1:0] wr_merged;

  logic              byp_en;
  logic [ADDR_W-1:0] byp_addr;
  logic [DATA_W-1:0] byp_data;

  logic              err_a, err_b;
  logic              addr_err_q;

  // User writes only land while no sweep owns the array.
  assign wr_in_range = {1'b0, bus.WrAddr} < DEPTH_L;
  assign wr_commit   = bus.WrEn && wr_in_range && (state_q == RF_IDLE);
  assign wr_old      = wr_in_range ? mem[bus.WrAddr] : RST_VAL;

  for (genvar i = 0; i < BE_W; i++) begin : g_lane
    assign wr_merged[8*i +: 8] = be_merge(wr_old[8*i +: 8], bus.WrData[8*i +: 8], bus.WrBe[i]);
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    clr_we  = 1'b0;
    case (state_q)
      RF_IDLE: begin
        if (bus.Clr) begin
          state_d = RF_SWEEP;
          ptr_d   = '0;
        end
      end
      RF_SWEEP: begin
        clr_we = 1'b1;
        if (ptr_q == LAST_PTR) begin
          state_d = RF_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: begin
        state_d = RF_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= RF_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= RST_VAL;
      end
    end else if (clr_we) begin
      mem[ptr_q] <= RST_VAL;
    end else if (wr_commit) begin
      mem[bus.WrAddr] <= wr_merged;
    end
  end

  // The clear write and a user write never coexist, so one bypass channel suffices.
  assign byp_en   = clr_we || wr_commit;
  assign byp_addr = clr_we ? ptr_q : bus.WrAddr;
  assign byp_data = clr_we ? RST_VAL : wr_merged;

  rf_read_port #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_rd_a (
    .CLK      (CLK),
    .RST      (RST),
    .rd_en    (bus.RdEnA),
    .rd_addr  (bus.RdAddrA),
    .mem      (mem),
    .byp_en   (byp_en),
    .byp_addr (byp_addr),
    .byp_data (byp_data),
    .rd_data  (bus.RdDataA),
    .rd_valid (bus.RdValidA),
    .addr_err (err_a)
  );

  rf_read_port #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_rd_b (
    .CLK      (CLK),
    .RST      (RST),
    .rd_en    (bus.RdEnB),
    .rd_addr  (bus.RdAddrB),
    .mem      (mem),
    .byp_en   (byp_en),
    .byp_addr (byp_addr),
    .byp_data (byp_data),
    .rd_data  (bus.RdDataB),
    .rd_valid (bus.RdValidB),
    .addr_err (err_b)
  );

  // Registered so the error pulse lines up with the read data of the offending cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      addr_err_q <= 1'b0;
    end else begin
      addr_err_q <= (bus.WrEn && (!wr_in_range || (state_q == RF_SWEEP))) || err_a || err_b;
    end
  end

  assign bus.AddrErr = addr_err_q;
  assign bus.ClrBusy = (state_q == RF_SWEEP);

endmodule

// File: tb/tb_regfile_2r1w.sv
// Scoreboard bench for regfile_2r1w: a DEPTH=8 and a DEPTH=6 instance share the
// same stimulus; a behavioural model predicts each cycle's outputs per instance.
module tb_regfile_2r1w;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  regfile_2r1w_if #(.DATA_W(16), .DEPTH(8)) bus8 ();
  regfile_2r1w_if #(.DATA_W(16), .DEPTH(6)) bus6 ();

  regfile_2r1w #(.DATA_W(16), .DEPTH(8), .RST_VAL(16'h0000)) dut8 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus8)
  );

  regfile_2r1w #(.DATA_W(16), .DEPTH(6), .RST_VAL(16'h0000)) dut6 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus6)
  );

  typedef struct packed {
    logic        vA;
    logic [15:0] dA;
    logic        vB;
    logic [15:0] dB;
    logic        busy;
    logic        err;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];

  int          checks = 0;
  int          errors = 0;
  int          depthOf [2] = '{8, 6};
  logic [15:0] mdl [2][8];
  logic        mBusy [2];
  int          mPtr [2];
  logic [15:0] lastA [2];
  logic [15:0] lastB [2];

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) mdl[d][i] = 16'h0000;
      mBusy[d] = 1'b0;
      mPtr[d]  = 0;
      lastA[d] = 16'h0000;
      lastB[d] = 16'h0000;
    end
  endtask

  task automatic monitorDut(input int d);
    exp_t        e;
    logic        vA, vB, busy, err;
    logic [15:0] dA, dB;
    if (d == 0) begin
      vA = bus8.RdValidA; dA = bus8.RdDataA; vB = bus8.RdValidB; dB = bus8.RdDataB;
      busy = bus8.ClrBusy; err = bus8.AddrErr;
      if (sb0.size() == 0) begin
        checkOutput("d0_sb_underflow", 32'd0, 32'd1);
        return;
      end
      e = sb0.pop_front();
    end else begin
      vA = bus6.RdValidA; dA = bus6.RdDataA; vB = bus6.RdValidB; dB = bus6.RdDataB;
      busy = bus6.ClrBusy; err = bus6.AddrErr;
      if (sb1.size() == 0) begin
        checkOutput("d1_sb_underflow", 32'd0, 32'd1);
        return;
      end
      e = sb1.pop_front();
    end
    checkOutput($sformatf("d%0d_validA", d), 32'(vA), 32'(e.vA));
    checkOutput($sformatf("d%0d_dataA", d), 32'(dA), 32'(e.dA));
    checkOutput($sformatf("d%0d_validB", d), 32'(vB), 32'(e.vB));
    checkOutput($sformatf("d%0d_dataB", d), 32'(dB), 32'(e.dB));
    checkOutput($sformatf("d%0d_clrBusy", d), 32'(busy), 32'(e.busy));
    checkOutput($sformatf("d%0d_addrErr", d), 32'(err), 32'(e.err));
  endtask

  // Drive one cycle on both instances, predict their outputs, then check after the edge.
  task automatic applyStimulus(
    input logic wrEn, input logic [2:0] wrAddr, input logic [15:0] wrData, input logic [1:0] wrBe,
    input logic rdEnA, input logic [2:0] rdAddrA, input logic rdEnB, input logic [2:0] rdAddrB,
    input logic clr
  );
    exp_t        e;
    logic [15:0] post [8];
    int          dep;
    bus8.WrEn = wrEn; bus8.WrAddr = wrAddr; bus8.WrData = wrData; bus8.WrBe = wrBe;
    bus8.RdEnA = rdEnA; bus8.RdAddrA = rdAddrA; bus8.RdEnB = rdEnB; bus8.RdAddrB = rdAddrB;
    bus8.Clr = clr;
    bus6.WrEn = wrEn; bus6.WrAddr = wrAddr; bus6.WrData = wrData; bus6.WrBe = wrBe;
    bus6.RdEnA = rdEnA; bus6.RdAddrA = rdAddrA; bus6.RdEnB = rdEnB; bus6.RdAddrB = rdAddrB;
    bus6.Clr = clr;
    for (int d = 0; d < 2; d++) begin
      dep = depthOf[d];
      for (int i = 0; i < 8; i++) post[i] = mdl[d][i];
      if (mBusy[d]) begin
        post[mPtr[d]] = 16'h0000;
      end else if (wrEn && int'(wrAddr) < dep) begin
        for (int b = 0; b < 2; b++) begin
          if (wrBe[b]) post[wrAddr][8*b +: 8] = wrData[8*b +: 8];
        end
      end
      e.err = (wrEn && (int'(wrAddr) >= dep || mBusy[d])) ||
              (rdEnA && int'(rdAddrA) >= dep) || (rdEnB && int'(rdAddrB) >= dep);
      if (rdEnA) lastA[d] = (int'(rdAddrA) < dep) ? post[rdAddrA] : 16'h0000;
      if (rdEnB) lastB[d] = (int'(rdAddrB) < dep) ? post[rdAddrB] : 16'h0000;
      e.vA = rdEnA; e.dA = lastA[d];
      e.vB = rdEnB; e.dB = lastB[d];
      if (mBusy[d]) begin
        if (mPtr[d] == dep - 1) begin
          mBusy[d] = 1'b0;
          mPtr[d]  = 0;
        end else begin
          mPtr[d] = mPtr[d] + 1;
        end
      end else if (clr) begin
        mBusy[d] = 1'b1;
        mPtr[d]  = 0;
      end
      e.busy = mBusy[d];
      for (int i = 0; i < 8; i++) mdl[d][i] = post[i];
      if (d == 0) sb0.push_back(e);
      else        sb1.push_back(e);
    end
    @(posedge CLK);
    #1;
    monitorDut(0);
    monitorDut(1);
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_d8_dataA"}, 32'(bus8.RdDataA), 32'h0);
    checkOutput({tag, "_d8_dataB"}, 32'(bus8.RdDataB), 32'h0);
    checkOutput({tag, "_d8_validA"}, 32'(bus8.RdValidA), 32'h0);
    checkOutput({tag, "_d8_validB"}, 32'(bus8.RdValidB), 32'h0);
    checkOutput({tag, "_d8_busy"}, 32'(bus8.ClrBusy), 32'h0);
    checkOutput({tag, "_d8_err"}, 32'(bus8.AddrErr), 32'h0);
    checkOutput({tag, "_d6_busy"}, 32'(bus6.ClrBusy), 32'h0);
    checkOutput({tag, "_d6_err"}, 32'(bus6.AddrErr), 32'h0);
  endtask

  task automatic fillAll(input logic [15:0] base);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 3'(i), base + 16'(i) * 16'h0101, 2'b11, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    end
  endtask

  task automatic readAll();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 3'd0, 16'h0, 2'b00, 1'b1, 3'(i), 1'b1, 3'(7 - i), 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RST = 1'b0;
    bus8.WrEn = 1'b0; bus8.WrAddr = '0; bus8.WrData = '0; bus8.WrBe = '0;
    bus8.RdEnA = 1'b0; bus8.RdAddrA = '0; bus8.RdEnB = 1'b0; bus8.RdAddrB = '0; bus8.Clr = 1'b0;
    bus6.WrEn = 1'b0; bus6.WrAddr = '0; bus6.WrData = '0; bus6.WrBe = '0;
    bus6.RdEnA = 1'b0; bus6.RdAddrA = '0; bus6.RdEnB = 1'b0; bus6.RdAddrB = '0; bus6.Clr = 1'b0;
    modelReset();
    repeat (2) @(posedge CLK);
    #1;
    checkQuiet("reset");
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;

    $display("[TB] reset reads");
    applyStimulus(1'b0, 3'd0, 16'h0, 2'b00, 1'b1, 3'd0, 1'b1, 3'd7, 1'b0);
    applyStimulus(1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);

    $display("[TB] byte-enable writes");
    applyStimulus(1'b1, 3'd3, 16'hBEEF, 2'b11, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    applyStimulus(1'b1, 3'd3, 16'h1234, 2'b01, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    applyStimulus(1'b0, 3'd0, 16'h0, 2'b00, 1'b1, 3'd3, 1'b1, 3'd3, 1'b0);
    applyStimulus(1'b1, 3'd3, 16'hFFFF, 2'b00, 1'b1, 3'd3, 1'b0, 3'd0, 1'b0);

    $display("[TB] bypass");
    applyStimulus(1'b1, 3'd5, 16'hA5A5, 2'b10, 1'b1, 3'd5, 1'b1, 3'd5, 1'b0);
    applyStimulus(1'b1, 3'd5, 16'h5A5A, 2'b01, 1'b0, 3'd0, 1'b1, 3'd5, 1'b0);

    $display("[TB] clear sweep");
    fillAll(16'h1000);
    readAll();
    applyStimulus(1'b1, 3'd2, 16'hCAFE, 2'b11, 1'b1, 3'd2, 1'b0, 3'd0, 1'b1);
    for (int c = 0; c < 10; c++) begin
      applyStimulus(c == 1, 3'd4, 16'hDEAD, 2'b11, 1'b1, 3'(c), 1'b1, 3'(c + 1), c == 3);
    end
    readAll();

    $display("[TB] out-of-range");
    fillAll(16'h2000);
    applyStimulus(1'b1, 3'd6, 16'h7777, 2'b11, 1'b1, 3'd6, 1'b1, 3'd7, 1'b0);
    applyStimulus(1'b1, 3'd5, 16'h5555, 2'b11, 1'b1, 3'd5, 1'b0, 3'd0, 1'b0);
    readAll();

    $display("[TB] reset mid-sweep");
    fillAll(16'h3000);
    applyStimulus(1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
    repeat (4) applyStimulus(1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    RST = 1'b0;
    #2;
    checkQuiet("midsweep_rst");
    modelReset();
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    checkQuiet("after_rst");
    readAll();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
